if_id_pipe_buf: RTL and testbench

Parametrised IF/ID pipeline register for the CPU core, placed between the instruction-fetch mux and the decode stage. Merges N independent stall requests (CPU hazard, AXI wait, …) and flushes on taken jump/branch by injecting a NOP bubble. Adds a small FIFO skid buffer, so instructions returned by memory during a stall are kept instead of lost. Provides per-cycle status and saturating performance counters.

---
 rtl/if_id_pipe_buf.sv | 160 ++++++++++++++++
 tb/tb_if_id_pipe_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_buf.sv
// IF/ID pipeline register with a small FIFO skid buffer.
// Merges stall sources and injects a NOP bubble on flush. Fetches returned
// during a stall are held in order. Also exports per-cycle status and
// saturating stall/flush counters.
module if_id_pipe_buf #(
  parameter int               XLEN       = 32,
  parameter int               ILEN       = 32,
  parameter int               N_STALL    = 2,
  parameter int               IBUF_DEPTH = 2,
  parameter logic [ILEN-1:0]  NOP_INST   = 32'h0000_0013,
  parameter int               CNT_W      = 16,
  // Derived widths; not intended to be overridden.
  parameter int               PTR_W      = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1,
  parameter int               BCNT_W     = $clog2(IBUF_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_STALL-1:0]  i_stall_req,
  input  logic                i_flush,
  input  logic                i_if_valid,
  input  logic [XLEN-1:0]     i_if_pc,
  input  logic [ILEN-1:0]     i_if_inst,
  output logic                o_if_ready,
  output logic                o_id_valid,
  output logic [XLEN-1:0]     o_id_pc,
  output logic [ILEN-1:0]     o_id_inst,
  output logic [1:0]          o_id_status,
  output logic [BCNT_W-1:0]   o_buf_count,
  input  logic                i_cnt_clr,
  output logic [CNT_W-1:0]    o_stall_cycles,
  output logic [CNT_W-1:0]    o_flush_events
);

  localparam logic [1:0] ST_BUBBLE = 2'd0;
  localparam logic [1:0] ST_ADV    = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(IBUF_DEPTH - 1);
  localparam logic [BCNT_W-1:0] BUF_FULL = BCNT_W'(IBUF_DEPTH);

  // Skid-buffer storage and bookkeeping
  logic [XLEN-1:0]   r_buf_pc   [IBUF_DEPTH];
  logic [ILEN-1:0]   r_buf_inst [IBUF_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [BCNT_W-1:0] r_count;

  // ID-stage registers
  logic              r_id_valid;
  logic [XLEN-1:0]   r_id_pc;
  logic [ILEN-1:0]   r_id_inst;
  logic [1:0]        r_id_status;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_events;

  logic w_stall;
  logic w_ready;
  logic w_accept;
  logic w_buf_empty;
  logic w_push;
  logic w_pop;

  assign w_stall     = |i_stall_req;
  assign w_ready     = (r_count < BUF_FULL);
  assign w_accept    = i_if_valid & w_ready;
  assign w_buf_empty = (r_count == '0);
  // A fetch is buffered while stalled, or while older entries still wait;
  // with an empty buffer and no stall it bypasses straight into ID.
  assign w_push      = w_accept & ~i_flush & (w_stall | ~w_buf_empty);
  assign w_pop       = ~i_flush & ~w_stall & ~w_buf_empty;

  // Store pushed fetch entries at the write pointer
  // NOTE: the storage array has no reset; stale contents are never observed
  // because r_count gates every read, and omitting the reset keeps it RAM-friendly.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= i_if_pc;
      r_buf_inst[r_wr_ptr] <= i_if_inst;
    end
  end

  // Advance FIFO pointers and occupancy; flush empties the buffer
  // NOTE: state registers use non-blocking assignments so every block sees
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Update the ID stage: flush > stall > pop head > bypass > bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_inst   <= NOP_INST;
      r_id_status <= ST_BUBBLE;
    end else if (i_flush) begin
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_inst   <= NOP_INST;
      r_id_status <= ST_FLUSH;
    end else if (w_stall) begin
      r_id_status <= ST_HOLD;
    end else if (!w_buf_empty) begin
      r_id_valid  <= 1'b1;
      r_id_pc     <= r_buf_pc[r_rd_ptr];
      r_id_inst   <= r_buf_inst[r_rd_ptr];
      r_id_status <= ST_ADV;
    end else if (w_accept) begin
      r_id_valid  <= 1'b1;
      r_id_pc     <= i_if_pc;
      r_id_inst   <= i_if_inst;
      r_id_status <= ST_ADV;
    end else begin
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_id_status <= ST_BUBBLE;
    end
  end

  // Saturating performance counters; clear overrides any increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall && !i_flush && r_stall_cycles != CNT_MAX)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (i_flush && r_flush_events != CNT_MAX)
        r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign o_if_ready     = w_ready;
  assign o_id_valid     = r_id_valid;
  assign o_id_pc        = r_id_pc;
  assign o_id_inst      = r_id_inst;
  assign o_id_status    = r_id_status;
  assign o_buf_count    = r_count;
  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Directed testbench for if_id_pipe_buf (IBUF_DEPTH=2, CNT_W=4).
module tb_if_id_pipe_buf;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int CNTW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      stall_req;
  logic            flush;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_inst;
  logic            if_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_inst;
  logic [1:0]      id_status;
  logic [1:0]      buf_count;
  logic            cnt_clr;
  logic [CNTW-1:0] stall_cycles;
  logic [CNTW-1:0] flush_events;

  int n_checks = 0;
  int n_errors = 0;

  if_id_pipe_buf #(
    .XLEN(XLEN), .ILEN(ILEN), .N_STALL(2), .IBUF_DEPTH(2),
    .NOP_INST(NOP), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_stall_req(stall_req), .i_flush(flush),
    .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_inst(if_inst),
    .o_if_ready(if_ready),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst),
    .o_id_status(id_status), .o_buf_count(buf_count),
    .i_cnt_clr(cnt_clr),
    .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = 32'hA000_0000 | pc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},  64'(id_valid),     64'd0);
    check({tag, "_pc"},     64'(id_pc),        64'd0);
    check({tag, "_inst"},   64'(id_inst),      64'(NOP));
    check({tag, "_status"}, 64'(id_status),    64'd0);
    check({tag, "_count"},  64'(buf_count),    64'd0);
    check({tag, "_ready"},  64'(if_ready),     64'd1);
    check({tag, "_stallc"}, 64'(stall_cycles), 64'd0);
    check({tag, "_flushc"}, 64'(flush_events), 64'd0);
  endtask

  initial begin
    rst = 1'b1; stall_req = '0; flush = 0; cnt_clr = 0;
    if_valid = 0; if_pc = '0; if_inst = '0;
    #12;
    check_reset_state("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch bypasses into ID after one edge
    if_valid = 1; if_pc = 32'h100; if_inst = 32'h0050_0093;
    step();
    check("t1_valid",  64'(id_valid),  64'd1);
    check("t1_pc",     64'(id_pc),     64'h100);
    check("t1_inst",   64'(id_inst),   64'h0050_0093);
    check("t1_status", 64'(id_status), 64'd1);
    check("t1_count",  64'(buf_count), 64'd0);

    // Stall three cycles while 0x104 and 0x108 arrive
    stall_req = 2'b10; fetch(1, 32'h104);
    step();
    check("t2a_pc",     64'(id_pc),     64'h100);
    check("t2a_status", 64'(id_status), 64'd3);
    check("t2a_count",  64'(buf_count), 64'd1);
    check("t2a_ready",  64'(if_ready),  64'd1);
    fetch(1, 32'h108);
    step();
    check("t2b_count",  64'(buf_count), 64'd2);
    check("t2b_ready",  64'(if_ready),  64'd0);
    check("t2b_pc",     64'(id_pc),     64'h100);
    fetch(1, 32'h1F0);  // not accepted: buffer full
    step();
    check("t2c_count",  64'(buf_count),    64'd2);
    check("t2c_status", 64'(id_status),    64'd3);
    check("t2c_valid",  64'(id_valid),     64'd1);
    check("t2c_stallc", 64'(stall_cycles), 64'd3);
    stall_req = 2'b00; fetch(0, 32'h0);
    step();
    check("t2d_pc",     64'(id_pc),     64'h104);
    check("t2d_inst",   64'(id_inst),   64'hA000_0104);
    check("t2d_status", 64'(id_status), 64'd1);
    check("t2d_count",  64'(buf_count), 64'd1);
    step();
    check("t2e_pc",     64'(id_pc),     64'h108);
    check("t2e_count",  64'(buf_count), 64'd0);
    step();
    check("t2f_valid",  64'(id_valid),  64'd0);
    check("t2f_inst",   64'(id_inst),   64'(NOP));
    check("t2f_pc",     64'(id_pc),     64'h108);
    check("t2f_status", 64'(id_status), 64'd0);

    // Fill buffer with two entries, then flush with a wrong-path fetch
    stall_req = 2'b01; fetch(1, 32'h300);
    step();
    fetch(1, 32'h304);
    step();
    check("t3_fill", 64'(buf_count), 64'd2);
    stall_req = 2'b00; flush = 1; fetch(1, 32'h10C);
    step();
    check("t3_valid",  64'(id_valid),     64'd0);
    check("t3_inst",   64'(id_inst),      64'(NOP));
    check("t3_pc",     64'(id_pc),        64'd0);
    check("t3_status", 64'(id_status),    64'd2);
    check("t3_count",  64'(buf_count),    64'd0);
    check("t3_flushc", 64'(flush_events), 64'd1);
    check("t3_stallc", 64'(stall_cycles), 64'd5);
    flush = 0; fetch(0, 32'h0);
    step();
    check("t3_nopass_valid", 64'(id_valid), 64'd0);
    check("t3_nopass_pc",    64'(id_pc),    64'd0);

    // Simultaneous push and pop keeps occupancy; order is preserved
    stall_req = 2'b01; fetch(1, 32'h400);
    step();
    check("t4_fill", 64'(buf_count), 64'd1);
    stall_req = 2'b00; fetch(1, 32'h200);
    step();
    check("t4a_pc",    64'(id_pc),     64'h400);
    check("t4a_count", 64'(buf_count), 64'd1);
    fetch(0, 32'h0);
    step();
    check("t4b_pc",     64'(id_pc),     64'h200);
    check("t4b_inst",   64'(id_inst),   64'hA000_0200);
    check("t4b_status", 64'(id_status), 64'd1);
    check("t4b_count",  64'(buf_count), 64'd0);

    // Stall and flush together: flush wins, stall not counted
    stall_req = 2'b11; flush = 1; fetch(1, 32'h500);
    step();
    check("t5_status", 64'(id_status),    64'd2);
    check("t5_valid",  64'(id_valid),     64'd0);
    check("t5_count",  64'(buf_count),    64'd0);
    check("t5_stallc", 64'(stall_cycles), 64'd6);
    check("t5_flushc", 64'(flush_events), 64'd2);
    flush = 0; fetch(0, 32'h0);

    // Counter saturation, then clear overriding a stall increment
    stall_req = 2'b10;
    for (int i = 0; i < 20; i++) step();
    check("t6_sat", 64'(stall_cycles), 64'd15);
    cnt_clr = 1;
    step();
    check("t6_clr_stall", 64'(stall_cycles), 64'd0);
    check("t6_clr_flush", 64'(flush_events), 64'd0);
    cnt_clr = 0;
    step();
    check("t6_recount", 64'(stall_cycles), 64'd1);

    // Asynchronous reset mid-stall with a full buffer
    fetch(1, 32'h600);
    step();
    fetch(1, 32'h604);
    step();
    check("t7_full", 64'(buf_count), 64'd2);
    fetch(0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_reset_state("t7_rst");
    stall_req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t7_after_valid", 64'(id_valid),  64'd0);
    check("t7_after_count", 64'(buf_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
